i2s_frame_ctrl: RTL

Sequencer for the I2S mic-to-amp loopback path. It derives BCLK/LRCLK from clk_25m and emits per-bit and per-slot strobes that the RX shifter and TX serializer use. It also runs the power-up/power-down sequence: mic warm-up with the amp muted, then amp enable, then a clean stop on a frame boundary.

---
 rtl/i2s_pkg.sv | 16 +
 rtl/i2s_bclk_gen.sv | 75 +++++++
 rtl/i2s_frame_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: sequencer state encoding and slot/frame geometry.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_STOP   = 2'd3
    } i2s_state_t;

    localparam int SLOT_BITS  = 32;
    localparam int FRAME_BITS = 64;
    localparam int SLOT_W     = $clog2(SLOT_BITS);
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK/LRCLK generator with per-bit strobes; the frame position counter idles at 63
// so the first falling edge after start opens left slot bit 0.
module i2s_bclk_gen
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 force_idle,
    output logic                 bclk,
    output logic                 lrclk,
    output logic [SLOT_W-1:0]    slot_bit,
    output logic                 bclk_rise,
    output logic                 bclk_fall,
    output logic                 frame_start,
    output logic                 fall_tick,
    output logic [BIT_CNT_W-1:0] bit_next
);

    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic                 toggle;

    assign toggle    = run && (div_cnt == DIV_LAST);
    assign fall_tick = toggle && bclk;
    assign bit_next  = bit_cnt + BIT_CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            bit_cnt     <= '1;
            bclk        <= 1'b0;
            lrclk       <= 1'b1;
            slot_bit    <= '1;
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
        end else if (!run || force_idle) begin
            // Idle values match reset so a restart always begins on a clean frame.
            div_cnt     <= '0;
            bit_cnt     <= '1;
            bclk        <= 1'b0;
            lrclk       <= 1'b1;
            slot_bit    <= '1;
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            bclk_rise   <= 1'b0;
            bclk_fall   <= 1'b0;
            frame_start <= 1'b0;
            if (toggle) begin
                div_cnt <= '0;
                bclk    <= ~bclk;
                if (!bclk) begin
                    bclk_rise <= 1'b1;
                end else begin
                    bit_cnt     <= bit_next;
                    lrclk       <= bit_next[BIT_CNT_W-1];
                    slot_bit    <= bit_next[SLOT_W-1:0];
                    bclk_fall   <= 1'b1;
                    frame_start <= (bit_next == '0);
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/i2s_frame_ctrl.sv
// I2S loopback sequencer: OFF -> WARMUP (amp muted) -> RUN -> STOP, stopping only
// on a frame boundary so the amp never sees a truncated frame.
module i2s_frame_ctrl
    import i2s_pkg::*;
#(
    parameter int BCLK_DIV      = 4,
    parameter int DATA_BITS     = 24,
    parameter int WARMUP_FRAMES = 2048
) (
    input  logic              clk_25m,
    input  logic              rst,
    input  logic              enable,
    output logic              bclk,
    output logic              lrclk,
    output logic              bclk_rise,
    output logic              bclk_fall,
    output logic [SLOT_W-1:0] slot_bit,
    output logic              frame_start,
    output logic              sample_strobe,
    output logic              sample_chan,
    output logic              amp_sd,
    output logic              mute,
    output logic [1:0]        state
);

    localparam int WCNT_W = $clog2(WARMUP_FRAMES + 1);
    localparam logic [WCNT_W-1:0] WARMUP_LAST = WCNT_W'(WARMUP_FRAMES - 1);
    localparam logic [SLOT_W-1:0] SAMPLE_BIT  = SLOT_W'((DATA_BITS + 1) % SLOT_BITS);
    // With 31 data bits the capture point lands on bit 0 of the following slot.
    localparam logic SAMPLE_WRAP = (DATA_BITS + 1 >= SLOT_BITS);

    i2s_state_t           state_q, state_d;
    logic [WCNT_W-1:0]    frame_cnt, frame_cnt_d;
    logic                 amp_sd_d, mute_d, sample_strobe_d, sample_chan_d;
    logic                 fall_tick, wrap_tick, gen_run, gen_idle;
    logic [BIT_CNT_W-1:0] bit_next;

    assign wrap_tick = fall_tick && (bit_next == '0);
    assign gen_run   = (state_q != ST_OFF);
    assign gen_idle  = (state_d == ST_OFF);
    assign state     = state_q;

    i2s_bclk_gen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_bclk_gen (
        .clk         (clk_25m),
        .rst         (rst),
        .run         (gen_run),
        .force_idle  (gen_idle),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .slot_bit    (slot_bit),
        .bclk_rise   (bclk_rise),
        .bclk_fall   (bclk_fall),
        .frame_start (frame_start),
        .fall_tick   (fall_tick),
        .bit_next    (bit_next)
    );

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) state_q <= ST_OFF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:    if (enable) state_d = ST_WARMUP;
            ST_WARMUP: begin
                if (!enable)                                   state_d = ST_OFF;
                else if (wrap_tick && frame_cnt == WARMUP_LAST) state_d = ST_RUN;
            end
            ST_RUN:    if (!enable) state_d = ST_STOP;
            ST_STOP:   if (wrap_tick) state_d = ST_OFF;
            default:   state_d = ST_OFF;
        endcase
    end

    always_comb begin
        frame_cnt_d = frame_cnt;
        if (state_q == ST_WARMUP && wrap_tick) frame_cnt_d = frame_cnt + WCNT_W'(1);
        if (state_q == ST_OFF || state_d == ST_OFF) frame_cnt_d = '0;

        amp_sd_d = (state_d == ST_RUN) || (state_d == ST_STOP);

        // The first frame in RUN stays muted so the amp can settle.
        mute_d = mute;
        if (state_d != ST_RUN)                        mute_d = 1'b1;
        else if (state_q == ST_RUN && wrap_tick)      mute_d = 1'b0;

        sample_strobe_d = fall_tick && !gen_idle && (bit_next[SLOT_W-1:0] == SAMPLE_BIT);
        sample_chan_d   = sample_strobe_d ? (bit_next[BIT_CNT_W-1] ^ SAMPLE_WRAP) : sample_chan;
    end

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            frame_cnt     <= '0;
            amp_sd        <= 1'b0;
            mute          <= 1'b1;
            sample_strobe <= 1'b0;
            sample_chan   <= 1'b0;
        end else begin
            frame_cnt     <= frame_cnt_d;
            amp_sd        <= amp_sd_d;
            mute          <= mute_d;
            sample_strobe <= sample_strobe_d;
            sample_chan   <= sample_chan_d;
        end
    end

endmodule
